ceespu_branch_resolve_ctrl: RTL

- Sequences the gshare predictor's update port and the pipeline's branch recovery.
- Records every predicted branch at fetch in an in-order in-flight queue.
- Matches execute-stage resolutions against the oldest entry, then drives predictor table updates and mispredict flush/redirect.
- Sits between fetch, execute and the predictor. It is the only source of the predictor's update_table, branch_address, branch_prediction_state and branch_taken inputs.

---
 rtl/ceespu_branch_resolve_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ceespu_branch_resolve_ctrl.sv
// ceespu_branch_resolve_ctrl
//
// Purpose: tracks every predicted branch from fetch in an in-order in-flight
// queue, matches execute-stage resolutions against the oldest entry, and
// drives the gshare predictor's update port plus the mispredict
// flush/redirect. After a flush, fetch is held off for RECOVER_CYCLES cycles.
//
// Handshake: fetch pushes when fetch_valid && fetch_ready in the same cycle.
// A fetch_valid seen while fetch_ready is low is dropped, not held. res_valid
// has no back-pressure. It pops the head when the queue is non-empty and the
// block is in RUN. In RECOVER it is ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fetch_valid/pc/state/pred/target/cond   branch recorded at fetch
//   fetch_ready                queue can accept a push this cycle (combinational)
//   res_valid/taken/target     resolution of the oldest in-flight branch
//   upd_valid/address/state/taken   predictor table update (registered)
//   flush, redirect_pc         one-cycle mispredict flush and restart PC
//   occupancy                  current queue entries
//   branch_count, mispredict_count  saturating statistics
//   res_error                  sticky: resolution arrived with the queue empty
module ceespu_branch_resolve_ctrl #(
    parameter int DEPTH_LOG2     = 2,
    parameter int PC_WIDTH       = 14,
    parameter int CNT_WIDTH      = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    input  logic [1:0]            fetch_state,
    input  logic                  fetch_pred,
    input  logic [PC_WIDTH-1:0]   fetch_target,
    input  logic                  fetch_cond,
    output logic                  fetch_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [PC_WIDTH-1:0]   res_target,
    output logic                  upd_valid,
    output logic [PC_WIDTH-1:0]   upd_address,
    output logic [1:0]            upd_state,
    output logic                  upd_taken,
    output logic                  flush,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    output logic                  res_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RCW   = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [1:0]          state;
        logic                pred;
        logic [PC_WIDTH-1:0] target;
        logic                cond;
    } entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    entry_t                queue_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    state_t                state;
    logic [RCW-1:0]        recover_cnt;

    entry_t head;
    logic   in_run;
    logic   full;
    logic   pop;
    logic   push;
    logic   mispredict;
    logic   do_flush;

    assign head   = queue_mem[rd_ptr];
    assign in_run = (state == RUN);
    // Occupancy never exceeds DEPTH, so its top bit alone means "full".
    assign full   = occupancy[DEPTH_LOG2];

    // A same-cycle resolution frees the head slot, so a full queue may still accept.
    assign fetch_ready = in_run && (!full || res_valid);
    assign push        = fetch_valid && fetch_ready;
    assign pop         = in_run && res_valid && (occupancy != '0);

    // Wrong direction, or right direction (taken) but wrong target.
    assign mispredict = (res_taken != head.pred) ||
                        (res_taken && head.pred && (res_target != head.target));
    assign do_flush   = pop && mispredict;

    // Storage carries no reset; pointers and occupancy define what is live.
    // A push alongside a flush is wrong-path work and is discarded.
    always_ff @(posedge clk) begin
        if (push && !do_flush) begin
            queue_mem[wr_ptr] <= '{pc: fetch_pc, state: fetch_state, pred: fetch_pred,
                                   target: fetch_target, cond: fetch_cond};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            occupancy        <= '0;
            state            <= RUN;
            recover_cnt      <= '0;
            upd_valid        <= 1'b0;
            upd_address      <= '0;
            upd_state        <= '0;
            upd_taken        <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            res_error        <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            flush     <= 1'b0;

            if (pop) begin
                // Unconditional branches are counted but never touch the table.
                upd_valid   <= head.cond;
                upd_address <= head.pc;
                upd_state   <= head.state;
                upd_taken   <= res_taken;
                if (branch_count != '1) begin
                    branch_count <= branch_count + CNT_WIDTH'(1);
                end
            end

            if (do_flush) begin
                flush       <= 1'b1;
                redirect_pc <= res_taken ? res_target : head.pc + PC_WIDTH'(1);
                if (mispredict_count != '1) begin
                    mispredict_count <= mispredict_count + CNT_WIDTH'(1);
                end
                // Everything younger than the mispredicted branch is wrong path.
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                occupancy   <= '0;
                state       <= RECOVER;
                recover_cnt <= RCW'(RECOVER_CYCLES - 1);
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    occupancy <= occupancy + 1'b1;
                end else if (pop && !push) begin
                    occupancy <= occupancy - 1'b1;
                end
                if (state == RECOVER) begin
                    if (recover_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        recover_cnt <= recover_cnt - 1'b1;
                    end
                end
            end

            if (in_run && res_valid && (occupancy == '0)) begin
                res_error <= 1'b1;
            end
        end
    end

endmodule
